// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: timed phase sequencer for a two-road intersection
// (north-south / east-west) with a pedestrian walk phase. Time advances in
// ticks, which are single-cycle enables from an upstream divider. Light,
// walk and phase outputs come straight from registers (Moore style).
module traffic_phase_ctrl #(
  parameter int unsigned GREEN_MIN = 2,  // minimum green, ticks
  parameter int unsigned GREEN_MAX = 6,  // maximum green under opposing demand, ticks
  parameter int unsigned YELLOW    = 3,  // yellow duration, ticks
  parameter int unsigned ALLRED    = 1,  // all-red clearance, ticks
  parameter int unsigned WALK      = 4   // pedestrian walk, ticks
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase,
  output logic       ped_pending
);

  typedef enum logic [2:0] {
    PH_ALLRED = 3'd0,
    PH_NS_G   = 3'd1,
    PH_NS_Y   = 3'd2,
    PH_EW_G   = 3'd3,
    PH_EW_Y   = 3'd4,
    PH_PED    = 3'd5
  } phase_e;

  // Light encoding {red,yellow,green}
  localparam logic [2:0] LT_RED    = 3'b100;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_GREEN  = 3'b001;

  // Durations widened to 9 bits so cnt+1 never wraps in the comparison
  localparam logic [8:0] L_GREEN_MIN = 9'(GREEN_MIN);
  localparam logic [8:0] L_GREEN_MAX = 9'(GREEN_MAX);
  localparam logic [8:0] L_YELLOW    = 9'(YELLOW);
  localparam logic [8:0] L_ALLRED    = 9'(ALLRED);
  localparam logic [8:0] L_WALK      = 9'(WALK);

  phase_e     r_phase;
  logic [7:0] r_cnt;
  logic       r_next_ew;
  logic       r_ped_pending;
  logic [2:0] r_ns_light;
  logic [2:0] r_ew_light;
  logic       r_walk;

  phase_e     w_next_phase;
  logic       w_next_ew;
  logic [8:0] w_served;
  logic       w_ns_opposing;
  logic       w_ew_opposing;
  logic       w_phase_change;
  logic       w_enter_ped;

  function automatic logic [2:0] ns_of(input phase_e p);
    case (p)
      PH_NS_G: ns_of = LT_GREEN;
      PH_NS_Y: ns_of = LT_YELLOW;
      default: ns_of = LT_RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_of(input phase_e p);
    case (p)
      PH_EW_G: ew_of = LT_GREEN;
      PH_EW_Y: ew_of = LT_YELLOW;
      default: ew_of = LT_RED;
    endcase
  endfunction

  // Ticks served in the current phase, counting the tick being applied now
  assign w_served      = {1'b0, r_cnt} + 9'd1;
  assign w_ns_opposing = car_ew | r_ped_pending;
  assign w_ew_opposing = car_ns | r_ped_pending;

  // Next-phase selection; transitions only happen on tick cycles
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    w_next_phase = r_phase;
    w_next_ew    = r_next_ew;
    case (r_phase)
      PH_ALLRED: begin
        if (tick && (w_served >= L_ALLRED)) begin
          if (r_ped_pending)  w_next_phase = PH_PED;
          else if (r_next_ew) w_next_phase = PH_EW_G;
          else                w_next_phase = PH_NS_G;
        end
      end
      PH_NS_G: begin
        // Max-out under demand, or gap-out once minimum served and NS is empty
        if (tick && w_ns_opposing &&
            ((w_served >= L_GREEN_MAX) || ((w_served >= L_GREEN_MIN) && !car_ns)))
          w_next_phase = PH_NS_Y;
      end
      PH_NS_Y: begin
        if (tick && (w_served >= L_YELLOW)) begin
          w_next_phase = PH_ALLRED;
          w_next_ew    = 1'b1;
        end
      end
      PH_EW_G: begin
        if (tick && w_ew_opposing &&
            ((w_served >= L_GREEN_MAX) || ((w_served >= L_GREEN_MIN) && !car_ew)))
          w_next_phase = PH_EW_Y;
      end
      PH_EW_Y: begin
        if (tick && (w_served >= L_YELLOW)) begin
          w_next_phase = PH_ALLRED;
          w_next_ew    = 1'b0;
        end
      end
      PH_PED: begin
        if (tick && (w_served >= L_WALK))
          w_next_phase = r_next_ew ? PH_EW_G : PH_NS_G;
      end
      default: begin
        // Codes 6/7 are unreachable; recover to a safe all-red start
        w_next_phase = PH_ALLRED;
        w_next_ew    = 1'b0;
      end
    endcase
  end

  assign w_phase_change = (w_next_phase != r_phase);
  assign w_enter_ped    = (w_next_phase == PH_PED) && (r_phase != PH_PED);

  // Phase register, tick counter, pedestrian latch and registered light outputs
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_phase       <= PH_ALLRED;
      r_cnt         <= 8'd0;
      r_next_ew     <= 1'b0;
      r_ped_pending <= 1'b0;
      r_ns_light    <= LT_RED;
      r_ew_light    <= LT_RED;
      r_walk        <= 1'b0;
    end else begin
      r_phase   <= w_next_phase;
      r_next_ew <= w_next_ew;

      if (w_phase_change)
        r_cnt <= 8'd0;
      else if (tick && (r_cnt != 8'hFF))
        r_cnt <= r_cnt + 8'd1;

      // Entering PED serves the request and absorbs a same-cycle press
      if (w_enter_ped)
        r_ped_pending <= 1'b0;
      else if (ped_req && (r_phase != PH_PED))
        r_ped_pending <= 1'b1;

      r_ns_light <= ns_of(w_next_phase);
      r_ew_light <= ew_of(w_next_phase);
      r_walk     <= (w_next_phase == PH_PED);
    end
  end

  assign ns_light    = r_ns_light;
  assign ew_light    = r_ew_light;
  assign walk        = r_walk;
  assign phase       = r_phase;
  assign ped_pending = r_ped_pending;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl. A behavioural model tracks
// phase, ticks served, the pedestrian latch and the green that follows
// clearance; a compare process checks every output against it each cycle,
// and directed sequences pin the model with hand-derived phase traces.
module tb_traffic_phase_ctrl;

  localparam int GMIN = 2;
  localparam int GMAX = 4;
  localparam int YEL  = 2;
  localparam int AR   = 1;
  localparam int WK   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b1;
  logic       car_ns = 1'b0;
  logic       car_ew = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic [2:0] phase;
  logic       ped_pending;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW(YEL), .ALLRED(AR), .WALK(WK)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .car_ns(car_ns), .car_ew(car_ew), .ped_req(ped_req),
    .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
    .phase(phase), .ped_pending(ped_pending)
  );

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase numbers: 0 all-red, 1 NS green, 2 NS yellow, 3 EW green, 4 EW yellow, 5 walk
  logic [2:0] ns_tab [6] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

  int m_phase   = 0;
  int m_served  = 0;   // ticks already spent in the current phase
  int m_np      = 0;
  bit m_next_ew = 1'b0;
  bit m_pend    = 1'b0;
  bit m_valid   = 1'b0;

  // Where the intersection goes when a tick lands, given the tick counts
  function automatic int model_next();
    int s;
    bit ns_road;
    bit mine;
    bit other;
    s = m_served + 1;
    case (m_phase)
      0: return (s >= AR) ? (m_pend ? 5 : (m_next_ew ? 3 : 1)) : 0;
      1, 3: begin
        ns_road = (m_phase == 1);
        mine    = ns_road ? car_ns : car_ew;
        other   = ns_road ? car_ew : car_ns;
        if ((other || m_pend) && (s >= GMAX || (s >= GMIN && !mine)))
          return m_phase + 1;
        return m_phase;
      end
      2, 4: return (s >= YEL) ? 0 : m_phase;
      5: return (s >= WK) ? (m_next_ew ? 3 : 1) : 5;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase   = 0;
      m_served  = 0;
      m_next_ew = 1'b0;
      m_pend    = 1'b0;
      m_valid   = 1'b1;
    end else if (m_valid) begin
      m_np = tick ? model_next() : m_phase;
      if (m_np == 5 && m_phase != 5) m_pend = 1'b0;
      else if (ped_req && m_phase != 5) m_pend = 1'b1;
      if (m_phase == 2 && m_np == 0) m_next_ew = 1'b1;
      if (m_phase == 4 && m_np == 0) m_next_ew = 1'b0;
      if (m_np != m_phase) m_served = 0;
      else if (tick && m_served < 255) m_served = m_served + 1;
      m_phase = m_np;
    end
  end

  // Every-cycle comparison against the model, plus the safety invariant
  always @(negedge clk) begin
    if (m_valid) begin
      check("phase", phase, m_phase);
      check("ns_light", ns_light, ns_tab[m_phase]);
      check("ew_light", ew_light, ew_tab[m_phase]);
      check("walk", walk, (m_phase == 5));
      check("ped_pending", ped_pending, m_pend);
      check("safety_one_road_red", (ns_light == 3'b100) || (ew_light == 3'b100), 1);
    end
  end

  // ---------------- directed stimulus ----------------
  int exp_q[$];
  int exp_pend_q[$];
  int exp_walk_q[$];
  bit div3 = 1'b0;

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Walk through exp_q one sample per cycle; sample 0 is the reset cycle.
  // ped_at pulses ped_req for one cycle; rst_at asserts reset for one cycle
  // and clears both car sensors afterwards.
  task automatic run_seq(input string name, input int ped_at, input int rst_at);
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_phase[%0d]", name, i), phase, exp_q[i]);
      if (i < exp_pend_q.size())
        check($sformatf("%s_pend[%0d]", name, i), ped_pending, exp_pend_q[i]);
      if (i < exp_walk_q.size())
        check($sformatf("%s_walk[%0d]", name, i), walk, exp_walk_q[i]);
      if (i == 0) begin
        check($sformatf("%s_reset_ns", name), ns_light, 3'b100);
        check($sformatf("%s_reset_ew", name), ew_light, 3'b100);
      end
      reset   = (i == rst_at);
      ped_req = (i == ped_at);
      if (rst_at >= 0 && i == rst_at + 1) begin
        car_ns = 1'b0;
        car_ew = 1'b0;
      end
      if (div3) tick = ((i + 1) % 3 == 0);
      @(negedge clk);
    end
    exp_pend_q.delete();
    exp_walk_q.delete();
  endtask

  initial begin
    // 1: no demand -> one all-red cycle, then NS green rests
    car_ns = 1'b0; car_ew = 1'b0; tick = 1'b1;
    do_reset();
    exp_q = {0};
    repeat (22) exp_q.push_back(1);
    run_seq("rest_ns", -1, -1);
    check("rest_ns_green", ns_light, 3'b001);

    // 2: EW demand only -> gap-out after minimum green, EW green rests
    car_ew = 1'b1; car_ns = 1'b0;
    do_reset();
    exp_q = {0, 1, 1, 2, 2, 0, 3, 3, 3, 3, 3, 3};
    run_seq("ew_only", -1, -1);
    check("ew_only_green", ew_light, 3'b001);

    // 3: both roads busy -> max-out cycling
    car_ew = 1'b1; car_ns = 1'b1;
    do_reset();
    exp_q = {0, 1, 1, 1, 1, 2, 2, 0, 3, 3, 3, 3, 4, 4, 0, 1, 1, 1, 1, 2, 2, 0, 3};
    run_seq("both", -1, -1);

    // 4: pedestrian press during NS green, no cars
    car_ew = 1'b0; car_ns = 1'b0;
    do_reset();
    exp_q      = {0, 1, 1, 1, 1, 2, 2, 0, 5, 5, 5, 3, 3};
    exp_pend_q = {0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    exp_walk_q = {0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    run_seq("ped", 3, -1);

    // 5: reset during EW yellow with a pending request, then resume to NS green
    car_ew = 1'b1; car_ns = 1'b1;
    do_reset();
    exp_q      = {0, 1, 1, 1, 1, 2, 2, 0, 3, 3, 3, 3, 4, 0, 1, 1};
    exp_pend_q = {0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    exp_walk_q = {0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_seq("mid_reset", 11, 12);

    // 6: tick every third cycle -> every duration triples
    car_ew = 1'b1; car_ns = 1'b0; div3 = 1'b1;
    do_reset();
    exp_q = {0, 0, 0, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 0, 0, 0, 3, 3, 3};
    run_seq("slow_tick", -1, -1);
    div3 = 1'b0;
    tick = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
